// File: rtl/sr_pkg.sv
// Shared types and helpers for the SR flop-bank drive sequencer.
// The excitation helper returns {s, r} for one lane.
package sr_pkg;

  typedef enum logic [1:0] {
    ST_INIT   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAULT  = 2'd3
  } state_t;

  localparam logic [1:0] SR_ILLEGAL = 2'b11;

  // Minimal excitation: drive only lanes that must change.
  function automatic logic [1:0] sr_excite(input logic m, input logic t);
    return {~m & t, m & ~t};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sr_drive_sequencer.sv
// Turns target words into legal S/R excitation for an SR flop bank and
// checks the bank's readback against the modelled state.
module sr_drive_sequencer
  import sr_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int ERR_W       = 8,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  input  logic [WIDTH-1:0] q_fb,
  input  logic             clear_err,
  output logic             mismatch,
  output logic [WIDTH-1:0] mismatch_lanes,
  output logic [ERR_W-1:0] err_count,
  output logic             fault
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] s_q, s_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] model_q, model_d;
  logic [WIDTH-1:0] model_d1_q, model_d1_d;
  logic             cmp_en_q, cmp_en_d;
  logic             mismatch_q, mismatch_d;
  logic [WIDTH-1:0] lanes_q, lanes_d;

  logic             accept;
  logic [WIDTH-1:0] cmp_lanes;
  logic             cmp_hit;
  logic [1:0]       ex;

  assign tgt_ready = (state_q == ST_RUN);
  assign accept    = tgt_valid && tgt_ready && !clear_err;
  assign cmp_lanes = q_fb ^ model_d1_q;
  assign cmp_hit   = cmp_en_q && (|cmp_lanes);

  always_comb begin
    state_d    = state_q;
    s_d        = '0;
    r_d        = '0;
    model_d    = model_q;
    model_d1_d = model_q;
    cmp_en_d   = cmp_en_q;
    mismatch_d = mismatch_q;
    lanes_d    = lanes_q;
    ex         = 2'b00;

    if (cmp_en_q) begin
      mismatch_d = |cmp_lanes;
      lanes_d    = cmp_lanes;
    end

    case (state_q)
      ST_INIT: begin
        r_d        = '1;
        model_d    = '0;
        model_d1_d = '0;
        cmp_en_d   = 1'b0;
        state_d    = ST_SETTLE;
      end
      ST_SETTLE: begin
        cmp_en_d = 1'b1;
        state_d  = ST_RUN;
      end
      ST_RUN: begin
        if (accept) begin
          for (int i = 0; i < WIDTH; i++) begin
            ex     = sr_excite(model_q[i], tgt_data[i]);
            s_d[i] = ex[1];
            r_d[i] = ex[0];
          end
          model_d = tgt_data;
        end
        if (STOP_ON_ERR && cmp_hit) begin
          state_d  = ST_FAULT;
          cmp_en_d = 1'b0;
        end
      end
      ST_FAULT: begin
        cmp_en_d = 1'b0;
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase

    // Clear overrides everything, including an accept on the same edge.
    if (clear_err) begin
      state_d    = ST_INIT;
      s_d        = '0;
      r_d        = '0;
      model_d    = model_q;
      cmp_en_d   = 1'b0;
      mismatch_d = 1'b0;
      lanes_d    = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_INIT;
      s_q        <= '0;
      r_q        <= '0;
      model_q    <= '0;
      model_d1_q <= '0;
      cmp_en_q   <= 1'b0;
      mismatch_q <= 1'b0;
      lanes_q    <= '0;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      r_q        <= r_d;
      model_q    <= model_d;
      model_d1_q <= model_d1_d;
      cmp_en_q   <= cmp_en_d;
      mismatch_q <= mismatch_d;
      lanes_q    <= lanes_d;
    end
  end

  sat_counter #(
    .WIDTH(ERR_W)
  ) u_err_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (cmp_hit && !clear_err),
    .clr  (clear_err),
    .count(err_count)
  );

  assign s              = s_q;
  assign r              = r_q;
  assign mismatch       = mismatch_q;
  assign mismatch_lanes = lanes_q;
  assign fault          = (state_q == ST_FAULT);

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// Directed bench: default instance with a behavioural SR bank in the loop,
// plus a 2-bit-counter, count-only instance for saturation.
module tb_sr_drive_sequencer;
  import sr_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       tgt_valid;
  logic [7:0] tgt_data;
  logic       clear_err;
  logic [7:0] inject;
  logic [7:0] bank_q = 8'hFF;
  logic [7:0] q_fb_a;

  logic       tgt_ready_a, mismatch_a, fault_a;
  logic [7:0] s_a, r_a, lanes_a, err_a;

  logic [7:0] q_fb_b;
  logic       tgt_ready_b, mismatch_b, fault_b;
  logic [7:0] s_b, r_b, lanes_b;
  logic [1:0] err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (s_a[i])      bank_q[i] <= 1'b1;
      else if (r_a[i]) bank_q[i] <= 1'b0;
    end
  end
  assign q_fb_a = bank_q | inject;

  sr_drive_sequencer #(.WIDTH(8), .ERR_W(8), .STOP_ON_ERR(1'b1)) dut_a (
    .clk(clk), .rst(rst), .tgt_valid(tgt_valid), .tgt_ready(tgt_ready_a),
    .tgt_data(tgt_data), .s(s_a), .r(r_a), .q_fb(q_fb_a), .clear_err(clear_err),
    .mismatch(mismatch_a), .mismatch_lanes(lanes_a), .err_count(err_a), .fault(fault_a)
  );

  sr_drive_sequencer #(.WIDTH(8), .ERR_W(2), .STOP_ON_ERR(1'b0)) dut_b (
    .clk(clk), .rst(rst), .tgt_valid(1'b0), .tgt_ready(tgt_ready_b),
    .tgt_data(8'h00), .s(s_b), .r(r_b), .q_fb(q_fb_b), .clear_err(1'b0),
    .mismatch(mismatch_b), .mismatch_lanes(lanes_b), .err_count(err_b), .fault(fault_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] illegal_lanes(input logic [7:0] sv, input logic [7:0] rv);
    logic [7:0] v;
    v = '0;
    for (int i = 0; i < 8; i++) v[i] = ({sv[i], rv[i]} == SR_ILLEGAL);
    return v;
  endfunction

  always @(negedge clk) begin
    if (!rst) chk("no_s_and_r", 32'(illegal_lanes(s_a, r_a)), 32'h0);
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_s"},     32'(s_a),         32'h0);
    chk({tag, "_r"},     32'(r_a),         32'h0);
    chk({tag, "_ready"}, 32'(tgt_ready_a), 32'h0);
    chk({tag, "_mis"},   32'(mismatch_a),  32'h0);
    chk({tag, "_lanes"}, 32'(lanes_a),     32'h0);
    chk({tag, "_err"},   32'(err_a),       32'h0);
    chk({tag, "_fault"}, 32'(fault_a),     32'h0);
  endtask

  task automatic bring_up(input string tag);
    tick();
    chk({tag, "_e1_r"},     32'(r_a),         32'hFF);
    chk({tag, "_e1_s"},     32'(s_a),         32'h00);
    chk({tag, "_e1_ready"}, 32'(tgt_ready_a), 32'h0);
    tick();
    chk({tag, "_e2_r"},     32'(r_a),         32'h00);
    chk({tag, "_e2_ready"}, 32'(tgt_ready_a), 32'h1);
    tick();
    chk({tag, "_e3_mis"},   32'(mismatch_a),  32'h0);
    chk({tag, "_e3_err"},   32'(err_a),       32'h0);
  endtask

  logic [1:0] sat_exp [6] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};

  initial begin
    rst       = 1'b1;
    tgt_valid = 1'b0;
    tgt_data  = 8'h00;
    clear_err = 1'b0;
    inject    = 8'h00;
    q_fb_b    = 8'h00;
    #2;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bring_up("bringup");

    // Saturation on the count-only instance.
    q_fb_b = 8'h01;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk($sformatf("sat_%0d", k), 32'(err_b), 32'(sat_exp[k]));
    end
    q_fb_b = 8'h00;
    chk("sat_fault_b", 32'(fault_b), 32'h0);

    // Excitation: 00 -> A5 -> 3C.
    tgt_valid = 1'b1;
    tgt_data  = 8'hA5;
    tick();
    chk("exc_a5_s", 32'(s_a), 32'hA5);
    chk("exc_a5_r", 32'(r_a), 32'h00);
    tgt_data = 8'h3C;
    tick();
    chk("exc_3c_s", 32'(s_a), 32'h18);
    chk("exc_3c_r", 32'(r_a), 32'h81);
    tgt_valid = 1'b0;
    tick();
    chk("idle_s", 32'(s_a), 32'h00);
    chk("idle_r", 32'(r_a), 32'h00);
    tick();
    tick();
    chk("exc_err", 32'(err_a), 32'h0);
    chk("exc_mis", 32'(mismatch_a), 32'h0);

    // Hold: 3C again, then 00 proves the model stayed at 3C.
    tgt_valid = 1'b1;
    tgt_data  = 8'h3C;
    tick();
    chk("hold_s", 32'(s_a), 32'h00);
    chk("hold_r", 32'(r_a), 32'h00);
    tgt_data = 8'h00;
    tick();
    chk("to00_s", 32'(s_a), 32'h00);
    chk("to00_r", 32'(r_a), 32'h3C);
    tgt_valid = 1'b0;
    tick();
    tick();
    chk("hold_err", 32'(err_a), 32'h0);

    // Fault injection on lane 2 while the model is 00.
    inject = 8'h04;
    tick();
    chk("flt_lanes", 32'(lanes_a),     32'h04);
    chk("flt_mis",   32'(mismatch_a),  32'h1);
    chk("flt_err",   32'(err_a),       32'h1);
    chk("flt_fault", 32'(fault_a),     32'h1);
    chk("flt_ready", 32'(tgt_ready_a), 32'h0);
    tick();
    chk("flt_err_held", 32'(err_a), 32'h1);
    chk("flt_s", 32'(s_a), 32'h00);
    chk("flt_r", 32'(r_a), 32'h00);
    inject = 8'h00;

    // clear_err with a simultaneous valid word: word must be dropped.
    clear_err = 1'b1;
    tgt_valid = 1'b1;
    tgt_data  = 8'hFF;
    tick();
    clear_err = 1'b0;
    tgt_valid = 1'b0;
    chk("clr_err",   32'(err_a),       32'h0);
    chk("clr_mis",   32'(mismatch_a),  32'h0);
    chk("clr_fault", 32'(fault_a),     32'h0);
    chk("clr_ready", 32'(tgt_ready_a), 32'h0);
    chk("clr_s",     32'(s_a),         32'h00);
    bring_up("reinit");

    // Mid-stream reset during back-to-back accepts with a bad readback.
    tgt_valid = 1'b1;
    tgt_data  = 8'hA5;
    tick();
    tgt_data = 8'h5A;
    tick();
    tgt_data = 8'hFF;
    inject   = 8'h80;
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tgt_valid = 1'b0;
    inject    = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    bring_up("postrst");
    tick();
    chk("postrst_mis", 32'(mismatch_a), 32'h0);
    chk("postrst_err", 32'(err_a),      32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
